pwm_capture: RTL
================

PWM_CAPTURE -- requirements
Module: pwm_capture

Interface
REQ-001 SHALL have parameter PRW, default 16: prescaler width.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: input synchronizer depth, minimum 2.
REQ-003 SHALL have port clk  input  1: single clock; one clock only, all logic on rising edge.
REQ-004 SHALL have port rst  input  1: synchronous, active-high reset.
REQ-005 SHALL have port cap_en  input  1: capture enable; low forces IDLE.
REQ-006 SHALL have port cap_in  input  1: asynchronous PWM input.
REQ-007 SHALL have port cap_inv  input  1: invert cap_in after synchronization.
REQ-008 SHALL have port oneshot  input  1: 1 = capture one period then stop; 0 = continuous.
REQ-009 SHALL have port prescaler  input  PRW: tick every prescaler+1 clocks.
REQ-010 SHALL have port timeout_val  input  32: tick count limit; 0 disables timeout.
REQ-011 SHALL have port flag_clr  input  1: clears sticky flags.
REQ-012 SHALL have port period  output  32: last measured period, in ticks.
REQ-013 SHALL have port high_time  output  32: last measured high time, in ticks.
REQ-014 SHALL have port cap_done  output  1: one-cycle pulse when period and high_time update.
REQ-015 SHALL have port timeout_flag  output  1: sticky, no edge within timeout_val ticks.
REQ-016 SHALL have port overflow_flag  output  1: sticky, counter saturated.
REQ-017 SHALL have port busy  output  1: high in ARM, HIGH, LOW.

Function
REQ-018 SHALL synchronize cap_in through SYNC_STAGES flops, XOR with cap_inv -> s; s_d = s delayed one clock; rise = s & ~s_d; fall = ~s & s_d.
REQ-019 Edge latency: an input transition SHALL be detected SYNC_STAGES+1 clocks after it is sampled.
REQ-020 Prescaler counter SHALL assert tick when it equals 0 and reload prescaler on tick, else decrement; while cap_en=0 it SHALL load prescaler; prescaler=0 gives tick every clock.
REQ-021 FSM states SHALL be IDLE, ARM, HIGH, LOW, DONE.
REQ-022 IDLE -> ARM when cap_en=1; any state -> IDLE next clock when cap_en=0 (highest priority, counter cleared, period/high_time retained).
REQ-023 ARM: counter held at 0; on rise -> HIGH.
REQ-024 Edge cycle (rise entering HIGH, or fall entering LOW) SHALL load counter with tick ? 1 : 0 only on rise; on fall counter continues counting (no reload).
REQ-025 HIGH/LOW non-edge cycles: counter SHALL increment by 1 on tick.
REQ-026 HIGH: on fall, latch hi_lat <= counter value before update, -> LOW.
REQ-027 LOW: on rise, period <= counter value before update, high_time <= hi_lat, cap_done=1 for that clock following register update, counter reloads per REQ-024; -> DONE if oneshot=1 else HIGH.
REQ-028 DONE: outputs held, busy=0; leaves only via cap_en=0.
REQ-029 Counter SHALL saturate at 32'hFFFF_FFFF; reaching it SHALL set overflow_flag and -> ARM, with no cap_done.
REQ-030 In HIGH/LOW, counter == timeout_val with timeout_val != 0 SHALL set timeout_flag and -> ARM, with no cap_done.
REQ-031 Priority within one clock: cap_en=0 > overflow > timeout > edge.
REQ-032 flag_clr SHALL clear both sticky flags; a same-clock set wins over clear.
REQ-033 period/high_time SHALL change only on cap_done; constant 0% or 100% duty produces no cap_done.

Reset
REQ-034 rst=1 SHALL, at next clk edge, force state IDLE, counter 0, prescaler counter 0, synchronizer flops and s_d to 0, period 0, high_time 0, cap_done 0, both flags 0, busy 0, regardless of state mid-measurement.

Verification
REQ-035 prescaler=0, cap_in period 100 clk, high 30 clk, continuous -> after first full period, cap_done every 100 clk with period=100, high_time=30.
REQ-036 prescaler=3, period 400 clk, high 100 clk -> period=100, high_time=25.
REQ-037 Same as REQ-035 with cap_inv=1 -> period=100, high_time=70.
REQ-038 cap_in held high after one rise, timeout_val=50, prescaler=0 -> timeout_flag set 50 clk after rise detection, state ARM, no cap_done; flag_clr clears it.
REQ-039 oneshot=1, 3 input periods -> exactly one cap_done, busy=0 afterwards; cap_en 0->1 re-arms.
REQ-040 rst asserted mid-LOW after one valid capture -> next clock all outputs 0, state IDLE.

Source files
------------

// File: rtl/pwm_capture.sv
// PWM period / high-time capture with a tick prescaler, timeout and overflow detection.
// cap_in is asynchronous; every other input and all logic use the rising edge of clk.
module pwm_capture #(
  parameter int unsigned PRW         = 16,
  parameter int unsigned SYNC_STAGES = 2   // must be at least 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cap_en,
  input  logic           cap_in,
  input  logic           cap_inv,
  input  logic           oneshot,
  input  logic [PRW-1:0] prescaler,
  input  logic [31:0]    timeout_val,
  input  logic           flag_clr,
  output logic [31:0]    period,
  output logic [31:0]    high_time,
  output logic           cap_done,
  output logic           timeout_flag,
  output logic           overflow_flag,
  output logic           busy
);

  typedef enum logic [2:0] {
    StIdle,
    StArm,
    StHigh,
    StLow,
    StDone
  } state_e;

  localparam logic [31:0] CntMax = 32'hFFFF_FFFF;

  state_e           state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic             s, s_d_q;
  logic             rise, fall;
  logic [PRW-1:0]   pcnt_q, pcnt_d;
  logic             tick;
  logic [31:0]      cnt_q, cnt_d;
  logic [31:0]      cnt_inc, edge_load;
  logic [31:0]      hi_lat_q, hi_lat_d;
  logic [31:0]      period_q, period_d;
  logic [31:0]      high_q, high_d;
  logic             done_q, done_d;
  logic             to_q, to_set;
  logic             ov_q, ov_set;
  logic             timeout_hit;

  // Input synchronizer and edge detector
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      s_d_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], cap_in};
      s_d_q  <= s;
    end
  end

  assign s    = sync_q[SYNC_STAGES-1] ^ cap_inv;
  assign rise = s & ~s_d_q;
  assign fall = ~s & s_d_q;

  // Prescaler: tick on zero, reload on tick; held at the reload value while disabled
  assign tick = (pcnt_q == '0);

  always_comb begin
    pcnt_d = pcnt_q;
    if (!cap_en || tick) begin
      pcnt_d = prescaler;
    end else begin
      pcnt_d = pcnt_q - PRW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_d;
    end
  end

  // Measurement FSM
  assign cnt_inc     = (tick && (cnt_q != CntMax)) ? cnt_q + 32'd1 : cnt_q;
  assign edge_load   = tick ? 32'd1 : 32'd0;
  assign timeout_hit = (timeout_val != 32'd0) && (cnt_q == timeout_val);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_lat_d = hi_lat_q;
    period_d = period_q;
    high_d   = high_q;
    done_d   = 1'b0;
    to_set   = 1'b0;
    ov_set   = 1'b0;

    if (!cap_en) begin
      state_d = StIdle;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          cnt_d   = '0;
          state_d = StArm;
        end
        StArm: begin
          cnt_d = '0;
          if (rise) begin
            cnt_d   = edge_load;
            state_d = StHigh;
          end
        end
        StHigh: begin
          if (cnt_q == CntMax) begin
            ov_set  = 1'b1;
            cnt_d   = '0;
            state_d = StArm;
          end else if (timeout_hit) begin
            to_set  = 1'b1;
            cnt_d   = '0;
            state_d = StArm;
          end else if (fall) begin
            // Period keeps running across the falling edge
            hi_lat_d = cnt_q;
            cnt_d    = cnt_inc;
            state_d  = StLow;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        StLow: begin
          if (cnt_q == CntMax) begin
            ov_set  = 1'b1;
            cnt_d   = '0;
            state_d = StArm;
          end else if (timeout_hit) begin
            to_set  = 1'b1;
            cnt_d   = '0;
            state_d = StArm;
          end else if (rise) begin
            period_d = cnt_q;
            high_d   = hi_lat_q;
            done_d   = 1'b1;
            cnt_d    = edge_load;
            state_d  = oneshot ? StDone : StHigh;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        StDone: begin
          cnt_d = cnt_q;
        end
        default: begin
          cnt_d   = '0;
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      hi_lat_q <= '0;
      period_q <= '0;
      high_q   <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_lat_q <= hi_lat_d;
      period_q <= period_d;
      high_q   <= high_d;
      done_q   <= done_d;
    end
  end

  // Sticky flags: a set in the same clock beats a clear
  always_ff @(posedge clk) begin
    if (rst) begin
      to_q <= 1'b0;
      ov_q <= 1'b0;
    end else begin
      if (to_set) begin
        to_q <= 1'b1;
      end else if (flag_clr) begin
        to_q <= 1'b0;
      end
      if (ov_set) begin
        ov_q <= 1'b1;
      end else if (flag_clr) begin
        ov_q <= 1'b0;
      end
    end
  end

  assign period        = period_q;
  assign high_time     = high_q;
  assign cap_done      = done_q;
  assign timeout_flag  = to_q;
  assign overflow_flag = ov_q;
  assign busy          = (state_q == StArm) || (state_q == StHigh) || (state_q == StLow);

endmodule
